afifo_wr_ctrl: RTL and testbench

Write-side controller of the asynchronous FIFO, in the wr_clk domain, directly upstream of the two-port RAM write port. Accepts write requests and generates the RAM write enable and address. Maintains the binary and Gray write pointers and brings the read-domain Gray pointer into wr_clk through a multi-stage synchronizer. Produces full, almost_full, write-side level and overflow status.

---
 rtl/afifo_pkg.sv | 32 +++
 rtl/ptr_sync.sv | 31 +++
 rtl/afifo_wr_ctrl.sv | 99 +++++++++
 tb/tb_afifo_wr_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO write and read controllers:
// Gray/binary conversion and the pointer-width rule.
package afifo_pkg;

  // Widest pointer the helpers handle. Narrower pointers are zero-extended
  // on the way in and truncated on the way out, which is exact for both
  // conversions because leading zeros map to leading zeros.
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] ptr_word_t;

  // Pointers carry one extra bit beyond the RAM address so that the
  // full and empty conditions can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int i = 1; i < GRAY_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Generic multi-stage synchronizer for Gray-coded pointers crossing clock
// domains. The stages reset to zero asynchronously.
module ptr_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the incoming pointer through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO. Drives the RAM write port,
// keeps the binary and Gray write pointers, synchronizes the read pointer
// into wr_clk and produces full, almost_full, level and overflow status.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  // The write pointer is exactly one lap ahead of the read pointer when the
  // two top Gray bits are inverted and the rest match. Building this as a
  // mask keeps the compare valid for the two-bit pointers of DEPTH=2.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("afifo_wr_ctrl: DEPTH must be a power of 2 and at least 2");
  end
  if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_width
    $error("afifo_wr_ctrl: ADDR_WIDTH must equal clog2(DEPTH)");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("afifo_wr_ctrl: SYNC_STAGES must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("afifo_wr_ctrl: AFULL_THRESH must lie in 1..DEPTH");
  end

  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] wr_bin_next;
  logic [PTR_W-1:0] wr_gray_next;
  logic [PTR_W-1:0] rd_gray_s;
  logic [PTR_W-1:0] rd_bin_s;
  logic [PTR_W-1:0] level_next;
  logic             accept;
  logic             full_next;

  // Only the Gray-coded read pointer crosses into wr_clk.
  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rd_gray_s)
  );

  // Next pointer values and status derived from this cycle's write and the
  // synchronized read pointer; a stale read pointer only over-reports level.
  always_comb begin
    accept       = wr_req & ~full;
    wr_bin_next  = wr_bin + PTR_W'(accept);
    wr_gray_next = PTR_W'(bin2gray(ptr_word_t'(wr_bin_next)));
    rd_bin_s     = PTR_W'(gray2bin(ptr_word_t'(rd_gray_s)));
    level_next   = wr_bin_next - rd_bin_s;
    full_next    = (wr_gray_next == (rd_gray_s ^ FULL_MASK));
  end

  assign ram_wr_en   = accept;
  assign ram_wr_addr = wr_bin[ADDR_WIDTH-1:0];

  // Register the pointers and all status outputs.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AFULL_LVL);
      wr_level    <= level_next;
      overflow    <= wr_req & full;
    end
  end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Self-checking bench for afifo_wr_ctrl: a DEPTH=16 instance and a DEPTH=2
// instance share clock and reset; a counter-based model predicts each cycle.
module tb_afifo_wr_ctrl;

  logic       wr_clk = 1'b0;
  logic       rst_n;
  logic       wr_req_a, wr_req_b;
  logic [4:0] rd_gray_a;
  logic [1:0] rd_gray_b;

  logic       ram_wr_en_a, full_a, almost_full_a, overflow_a;
  logic [3:0] ram_wr_addr_a;
  logic [4:0] wr_ptr_gray_a, wr_level_a;

  logic       ram_wr_en_b, full_b, almost_full_b, overflow_b;
  logic [0:0] ram_wr_addr_b;
  logic [1:0] wr_ptr_gray_b, wr_level_b;

  always #5 wr_clk = ~wr_clk;

  afifo_wr_ctrl #(.DEPTH(16), .SYNC_STAGES(2), .AFULL_THRESH(14)) u_dut_a (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req_a),
    .rd_ptr_gray (rd_gray_a),
    .ram_wr_en   (ram_wr_en_a),
    .ram_wr_addr (ram_wr_addr_a),
    .wr_ptr_gray (wr_ptr_gray_a),
    .full        (full_a),
    .almost_full (almost_full_a),
    .wr_level    (wr_level_a),
    .overflow    (overflow_a)
  );

  afifo_wr_ctrl #(.DEPTH(2), .SYNC_STAGES(2), .AFULL_THRESH(1)) u_dut_b (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req_b),
    .rd_ptr_gray (rd_gray_b),
    .ram_wr_en   (ram_wr_en_b),
    .ram_wr_addr (ram_wr_addr_b),
    .wr_ptr_gray (wr_ptr_gray_b),
    .full        (full_b),
    .almost_full (almost_full_b),
    .wr_level    (wr_level_b),
    .overflow    (overflow_b)
  );

  typedef struct {int dut; int en; int addr;} comb_t;
  typedef struct {int dut; int gray; int full; int afull; int ovf; int level; int acc;} reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  int checkCount = 0;
  int passCount  = 0;

  int dep[2] = '{16, 2};
  int thr[2] = '{14, 1};
  int m_wr[2], m_p0[2], m_p1[2], m_full[2], tot_wr[2], prev_gray[2];

  function automatic int toGray(input int c);
    return c ^ (c >> 1);
  endfunction

  function automatic int obsEn(input int d);
    return (d == 0) ? int'(ram_wr_en_a) : int'(ram_wr_en_b);
  endfunction
  function automatic int obsAddr(input int d);
    return (d == 0) ? int'(ram_wr_addr_a) : int'(ram_wr_addr_b);
  endfunction
  function automatic int obsGray(input int d);
    return (d == 0) ? int'(wr_ptr_gray_a) : int'(wr_ptr_gray_b);
  endfunction
  function automatic int obsFull(input int d);
    return (d == 0) ? int'(full_a) : int'(full_b);
  endfunction
  function automatic int obsAfull(input int d);
    return (d == 0) ? int'(almost_full_a) : int'(almost_full_b);
  endfunction
  function automatic int obsLevel(input int d);
    return (d == 0) ? int'(wr_level_a) : int'(wr_level_b);
  endfunction
  function automatic int obsOvf(input int d);
    return (d == 0) ? int'(overflow_a) : int'(overflow_b);
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    if (obs == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = 0; m_p0[d] = 0; m_p1[d] = 0; m_full[d] = 0;
      tot_wr[d] = 0; prev_gray[d] = 0;
    end
  endtask

  // Assert reset between clock edges; outputs must clear immediately.
  task automatic doReset();
    @(negedge wr_clk);
    wr_req_a = 1'b0; wr_req_b = 1'b0;
    rd_gray_a = '0;  rd_gray_b = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d rst ram_wr_en", d), obsEn(d), 0);
      checkOutput($sformatf("d%0d rst addr", d), obsAddr(d), 0);
      checkOutput($sformatf("d%0d rst gray", d), obsGray(d), 0);
      checkOutput($sformatf("d%0d rst full", d), obsFull(d), 0);
      checkOutput($sformatf("d%0d rst afull", d), obsAfull(d), 0);
      checkOutput($sformatf("d%0d rst level", d), obsLevel(d), 0);
      checkOutput($sformatf("d%0d rst overflow", d), obsOvf(d), 0);
    end
    modelReset();
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
  endtask

  // One wr_clk cycle: drive both instances, push expectations, then check.
  task automatic applyStimulus(input int req_a, input int rd_a, input int req_b, input int rd_b);
    int    req[2];
    int    rdc[2];
    int    acc, nw, lvl, two;
    comb_t c;
    reg_t  r;
    req[0] = req_a; req[1] = req_b;
    rdc[0] = rd_a;  rdc[1] = rd_b;
    @(negedge wr_clk);
    wr_req_a  = (req_a != 0);
    wr_req_b  = (req_b != 0);
    rd_gray_a = 5'(toGray(rd_a % 32));
    rd_gray_b = 2'(toGray(rd_b % 4));
    for (int d = 0; d < 2; d++) begin
      two    = 2 * dep[d];
      acc    = (req[d] != 0 && m_full[d] == 0) ? 1 : 0;
      c.dut  = d; c.en = acc; c.addr = m_wr[d] % dep[d];
      comb_q.push_back(c);
      nw     = (m_wr[d] + acc) % two;
      lvl    = (nw - m_p1[d] + two) % two;
      r.dut  = d;
      r.gray = toGray(nw);
      r.full = (lvl == dep[d]) ? 1 : 0;
      r.afull = (lvl >= thr[d]) ? 1 : 0;
      r.ovf  = (req[d] != 0 && m_full[d] != 0) ? 1 : 0;
      r.level = lvl;
      r.acc  = acc;
      reg_q.push_back(r);
      m_full[d] = r.full;
      m_wr[d]   = nw;
      m_p1[d]   = m_p0[d];
      m_p0[d]   = rdc[d] % two;
      tot_wr[d] += acc;
    end
    #1;
    while (comb_q.size() > 0) begin
      c = comb_q.pop_front();
      checkOutput($sformatf("d%0d ram_wr_en", c.dut), obsEn(c.dut), c.en);
      checkOutput($sformatf("d%0d ram_wr_addr", c.dut), obsAddr(c.dut), c.addr);
    end
    @(posedge wr_clk);
    #1;
    while (reg_q.size() > 0) begin
      r = reg_q.pop_front();
      checkOutput($sformatf("d%0d wr_ptr_gray", r.dut), obsGray(r.dut), r.gray);
      checkOutput($sformatf("d%0d gray bit changes", r.dut),
                  $countones(obsGray(r.dut) ^ prev_gray[r.dut]), r.acc);
      prev_gray[r.dut] = obsGray(r.dut);
      checkOutput($sformatf("d%0d full", r.dut), obsFull(r.dut), r.full);
      checkOutput($sformatf("d%0d almost_full", r.dut), obsAfull(r.dut), r.afull);
      checkOutput($sformatf("d%0d wr_level", r.dut), obsLevel(r.dut), r.level);
      checkOutput($sformatf("d%0d overflow", r.dut), obsOvf(r.dut), r.ovf);
    end
  endtask

  initial begin
    int rdA;
    rst_n = 1'b1;
    wr_req_a = 1'b0; wr_req_b = 1'b0;
    rd_gray_a = '0;  rd_gray_b = '0;
    modelReset();
    doReset();

    // Fill DEPTH=16 with the reader parked at 0, then push against full.
    repeat (16) applyStimulus(1, 0, 0, 0);
    checkOutput("a full after fill", int'(full_a), 1);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("a gray held while full", int'(wr_ptr_gray_a), 24);

    // Reader advances by one; full drops after the synchronizer delay.
    repeat (3) applyStimulus(0, 1, 0, 0);
    checkOutput("a full released", int'(full_a), 0);
    applyStimulus(1, 1, 0, 0);
    for (int r = 2; r <= 17; r++) applyStimulus(0, r, 0, 0);
    repeat (3) applyStimulus(0, 17, 0, 0);

    // Interleaved writes and reads across two pointer wraps.
    doReset();
    rdA = 0;
    for (int i = 0; i < 40; i++) begin
      if (tot_wr[0] - 3 > rdA) rdA = tot_wr[0] - 3;
      applyStimulus(1, rdA, 0, 0);
    end
    checkOutput("a writes accepted", tot_wr[0], 40);
    while (rdA < tot_wr[0]) begin
      rdA++;
      applyStimulus(0, rdA, 0, 0);
    end
    repeat (3) applyStimulus(0, rdA, 0, 0);

    // Reset in the middle of a burst at level 9.
    doReset();
    repeat (9) applyStimulus(1, 0, 0, 0);
    checkOutput("a level before reset", int'(wr_level_a), 9);
    doReset();
    applyStimulus(1, 0, 0, 0);

    // DEPTH=2 with almost_full at level 1.
    repeat (3) applyStimulus(0, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
